decode_control: RTL and testbench

- Combinational RV32I instruction decoder and control unit for the single-cycle core.
- Takes the fetched instruction and both register-file read values.
- Drives all datapath selects, enables, register indices and the sign-extended immediate.
- A two-state sequencer clears the register file after reset before normal decoding starts.

---
 rtl/decode_pkg.sv | 46 ++++
 rtl/decode_imm_gen.sv | 33 +++
 rtl/decode_control.sv | 180 ++++++++++++++++++
 tb/tb_decode_control.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/decode_pkg.sv
// Shared RV32I decode constants: opcodes, ALU codes, RF data-in and memory size selects.
`default_nettype none

package decode_pkg;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_AND = 3'd2,
    ALU_OR  = 3'd3,
    ALU_XOR = 3'd4,
    ALU_SLL = 3'd5,
    ALU_SRL = 3'd6,
    ALU_SRA = 3'd7
  } alu_op_t;

  localparam logic [1:0] RFD_PC4  = 2'd0;
  localparam logic [1:0] RFD_ALU  = 2'd1;
  localparam logic [1:0] RFD_DMEM = 2'd2;

  localparam logic [1:0] MEM_BYTE = 2'd0;
  localparam logic [1:0] MEM_HALF = 2'd1;
  localparam logic [1:0] MEM_WORD = 2'd2;

  typedef enum logic [2:0] {
    IMM_NONE = 3'd0,
    IMM_I    = 3'd1,
    IMM_S    = 3'd2,
    IMM_B    = 3'd3,
    IMM_U    = 3'd4,
    IMM_J    = 3'd5
  } imm_fmt_t;

endpackage

`default_nettype wire

// File: rtl/decode_imm_gen.sv
// Immediate extraction and sign extension for the I/S/B/U/J instruction formats.
`default_nettype none

module decode_imm_gen
  import decode_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:7]     instruction,
  input  imm_fmt_t        fmt,
  output logic [XLEN-1:0] immediate
);

  logic sign;
  assign sign = instruction[31];

  always_comb begin
    immediate = '0;
    unique case (fmt)
      IMM_I: immediate = {{(XLEN-12){sign}}, instruction[31:20]};
      IMM_S: immediate = {{(XLEN-12){sign}}, instruction[31:25], instruction[11:7]};
      IMM_B: immediate = {{(XLEN-13){sign}}, instruction[31], instruction[7],
                          instruction[30:25], instruction[11:8], 1'b0};
      IMM_U: immediate = {{(XLEN-32){sign}}, instruction[31:12], 12'b0};
      IMM_J: immediate = {{(XLEN-21){sign}}, instruction[31], instruction[19:12],
                          instruction[20], instruction[30:21], 1'b0};
      default: immediate = '0;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/decode_control.sv
// RV32I decoder/control unit with a post-reset register-file clear sequencer.
// Optional ILLEGAL output enabled by DECODE_ILLEGAL_FLAG_EN.
`default_nettype none

module decode_control
  import decode_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clock,
  input  logic            reset_n,
  input  logic [XLEN-1:0] instruction,
  input  logic [XLEN-1:0] REG_1,
  input  logic [XLEN-1:0] REG_2,
  output logic            PC_IN_MUX_SEL,
  output logic            ALU_OP_1_MUX_SEL,
  output logic            ALU_OP_2_MUX_SEL,
  output logic [2:0]      ALU_OPCODE,
  output logic            RF_WR_EN,
  output logic            RF_SET,
  output logic            RF_RESET,
  output logic [1:0]      RF_DATA_IN_MUX_SEL,
  output logic            DATA_MEMORY_WR_EN,
  output logic [1:0]      DATA_MEMORY_SIZE_SEL,
  output logic            DATA_MEMORY_SIGN_EXTEND,
  output logic [XLEN-1:0] immediate,
  output logic [4:0]      RF_SEL_1,
  output logic [4:0]      RF_SEL_2,
`ifdef DECODE_ILLEGAL_FLAG_EN
  output logic            ILLEGAL,
`endif
  output logic [4:0]      RF_SEL_RD
);

  typedef enum logic [0:0] {ST_INIT = 1'b0, ST_RUN = 1'b1} state_t;
  state_t state;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state    <= ST_INIT;
      RF_RESET <= 1'b1;
    end else begin
      state    <= ST_RUN;
      RF_RESET <= 1'b0;
    end
  end

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       alt;
  assign opcode = instruction[6:0];
  assign funct3 = instruction[14:12];
  assign alt    = instruction[30];

  logic       d_pc_sel, d_op1_sel, d_op2_sel, d_rf_we, d_dm_we, d_sext, illegal, taken;
  logic [1:0] d_din, d_size;
  logic [4:0] d_sel1;
  alu_op_t    d_alu;
  imm_fmt_t   d_fmt;
  logic [XLEN-1:0] imm_raw;

  always_comb begin
    d_pc_sel  = 1'b0;
    d_op1_sel = 1'b1;
    d_op2_sel = 1'b0;
    d_alu     = ALU_ADD;
    d_rf_we   = 1'b0;
    d_din     = RFD_ALU;
    d_dm_we   = 1'b0;
    d_size    = MEM_BYTE;
    d_sext    = 1'b0;
    d_fmt     = IMM_NONE;
    d_sel1    = instruction[19:15];
    illegal   = 1'b0;
    taken     = 1'b0;
    case (opcode)
      OPC_LUI: begin
        d_op2_sel = 1'b1; d_fmt = IMM_U; d_rf_we = 1'b1; d_sel1 = 5'd0;
      end
      OPC_AUIPC: begin
        d_op1_sel = 1'b0; d_op2_sel = 1'b1; d_fmt = IMM_U; d_rf_we = 1'b1;
      end
      OPC_JAL: begin
        d_op1_sel = 1'b0; d_op2_sel = 1'b1; d_fmt = IMM_J;
        d_pc_sel  = 1'b1; d_rf_we = 1'b1; d_din = RFD_PC4;
      end
      OPC_JALR: begin
        d_op2_sel = 1'b1; d_fmt = IMM_I;
        d_pc_sel  = 1'b1; d_rf_we = 1'b1; d_din = RFD_PC4;
        illegal   = (funct3 != 3'b000);
      end
      OPC_BRANCH: begin
        d_op1_sel = 1'b0; d_op2_sel = 1'b1; d_fmt = IMM_B;
        case (funct3)
          3'b000:  taken = (REG_1 == REG_2);
          3'b001:  taken = (REG_1 != REG_2);
          3'b100:  taken = ($signed(REG_1) <  $signed(REG_2));
          3'b101:  taken = ($signed(REG_1) >= $signed(REG_2));
          3'b110:  taken = (REG_1 <  REG_2);
          3'b111:  taken = (REG_1 >= REG_2);
          default: illegal = 1'b1;
        endcase
        d_pc_sel = taken;
      end
      OPC_LOAD: begin
        d_op2_sel = 1'b1; d_fmt = IMM_I; d_rf_we = 1'b1; d_din = RFD_DMEM;
        d_size    = funct3[1:0]; d_sext = !funct3[2];
        illegal   = (funct3[1:0] == 2'b11) || (funct3 == 3'b110);
      end
      OPC_STORE: begin
        d_op2_sel = 1'b1; d_fmt = IMM_S; d_dm_we = 1'b1; d_size = funct3[1:0];
        illegal   = funct3[2] || (funct3[1:0] == 2'b11);
      end
      OPC_OP_IMM, OPC_OP: begin
        // Only ADD/SUB and SRL/SRA are distinguished by bit 30; SUB has no immediate form.
        d_op2_sel = (opcode == OPC_OP_IMM);
        d_fmt     = (opcode == OPC_OP_IMM) ? IMM_I : IMM_NONE;
        d_rf_we   = 1'b1;
        case (funct3)
          3'b000:  d_alu = (alt && opcode == OPC_OP) ? ALU_SUB : ALU_ADD;
          3'b001:  d_alu = ALU_SLL;
          3'b100:  d_alu = ALU_XOR;
          3'b101:  d_alu = alt ? ALU_SRA : ALU_SRL;
          3'b110:  d_alu = ALU_OR;
          3'b111:  d_alu = ALU_AND;
          default: illegal = 1'b1;
        endcase
      end
      default: illegal = 1'b1;
    endcase

    if (illegal) begin
      d_pc_sel  = 1'b0;
      d_op1_sel = 1'b1;
      d_op2_sel = 1'b0;
      d_alu     = ALU_ADD;
      d_rf_we   = 1'b0;
      d_din     = RFD_ALU;
      d_dm_we   = 1'b0;
      d_size    = MEM_BYTE;
      d_sext    = 1'b0;
      d_fmt     = IMM_NONE;
      d_sel1    = instruction[19:15];
    end
    if (instruction[11:7] == 5'd0) d_rf_we = 1'b0;
  end

  decode_imm_gen #(.XLEN(XLEN)) u_imm_gen (
    .instruction (instruction[31:7]),
    .fmt         (d_fmt),
    .immediate   (imm_raw)
  );

  logic run;
  assign run = (state == ST_RUN);

  always_comb begin
    PC_IN_MUX_SEL           = run & d_pc_sel;
    ALU_OP_1_MUX_SEL        = run & d_op1_sel;
    ALU_OP_2_MUX_SEL        = run & d_op2_sel;
    ALU_OPCODE              = run ? d_alu : 3'd0;
    RF_WR_EN                = run & d_rf_we;
    RF_SET                  = 1'b0;
    RF_DATA_IN_MUX_SEL      = run ? d_din : 2'd0;
    DATA_MEMORY_WR_EN       = run & d_dm_we;
    DATA_MEMORY_SIZE_SEL    = run ? d_size : 2'd0;
    DATA_MEMORY_SIGN_EXTEND = run & d_sext;
    immediate               = run ? imm_raw : '0;
    RF_SEL_1                = run ? d_sel1 : 5'd0;
    RF_SEL_2                = run ? instruction[24:20] : 5'd0;
    RF_SEL_RD               = run ? instruction[11:7] : 5'd0;
  end

`ifdef DECODE_ILLEGAL_FLAG_EN
  assign ILLEGAL = run & illegal;
`endif

endmodule

`default_nettype wire

// File: tb/tb_decode_control.sv
// Table-driven scoreboard bench for decode_control.
`default_nettype none

module tb_decode_control;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic [31:0] instruction = '0, REG_1 = '0, REG_2 = '0;
  logic        PC_IN_MUX_SEL, ALU_OP_1_MUX_SEL, ALU_OP_2_MUX_SEL, RF_WR_EN, RF_SET, RF_RESET;
  logic        DATA_MEMORY_WR_EN, DATA_MEMORY_SIGN_EXTEND;
  logic [2:0]  ALU_OPCODE;
  logic [1:0]  RF_DATA_IN_MUX_SEL, DATA_MEMORY_SIZE_SEL;
  logic [31:0] immediate;
  logic [4:0]  RF_SEL_1, RF_SEL_2, RF_SEL_RD;
`ifdef DECODE_ILLEGAL_FLAG_EN
  logic        ILLEGAL;
`endif

  always #5 clock = ~clock;

  decode_control #(.XLEN(32)) dut (
    .clock(clock), .reset_n(reset_n), .instruction(instruction),
    .REG_1(REG_1), .REG_2(REG_2),
    .PC_IN_MUX_SEL(PC_IN_MUX_SEL), .ALU_OP_1_MUX_SEL(ALU_OP_1_MUX_SEL),
    .ALU_OP_2_MUX_SEL(ALU_OP_2_MUX_SEL), .ALU_OPCODE(ALU_OPCODE),
    .RF_WR_EN(RF_WR_EN), .RF_SET(RF_SET), .RF_RESET(RF_RESET),
    .RF_DATA_IN_MUX_SEL(RF_DATA_IN_MUX_SEL), .DATA_MEMORY_WR_EN(DATA_MEMORY_WR_EN),
    .DATA_MEMORY_SIZE_SEL(DATA_MEMORY_SIZE_SEL),
    .DATA_MEMORY_SIGN_EXTEND(DATA_MEMORY_SIGN_EXTEND),
    .immediate(immediate), .RF_SEL_1(RF_SEL_1), .RF_SEL_2(RF_SEL_2),
`ifdef DECODE_ILLEGAL_FLAG_EN
    .ILLEGAL(ILLEGAL),
`endif
    .RF_SEL_RD(RF_SEL_RD)
  );

  typedef struct packed {
    logic        pc, op1, op2;
    logic [2:0]  alu;
    logic        we, set, rst;
    logic [1:0]  din;
    logic        dmwe;
    logic [1:0]  size;
    logic        sext;
    logic [31:0] imm;
    logic [4:0]  s1, s2, rd;
  } out_t;

  typedef struct {
    logic [31:0] instr, r1, r2;
    out_t        exp;
    logic        ill;
    string       name;
  } vec_t;

  vec_t  vecs[$];
  out_t  sb_exp[$];
  logic  sb_ill[$];
  string sb_name[$];
  int    checks = 0;
  int    errors = 0;

  function automatic out_t mk(logic pc, logic op1, logic op2, logic [2:0] alu, logic we,
                              logic [1:0] din, logic dmwe, logic [1:0] size, logic sext,
                              logic [31:0] imm, logic [4:0] s1, logic [4:0] s2, logic [4:0] rd);
    out_t o;
    o = '{pc:pc, op1:op1, op2:op2, alu:alu, we:we, set:1'b0, rst:1'b0, din:din, dmwe:dmwe,
          size:size, sext:sext, imm:imm, s1:s1, s2:s2, rd:rd};
    return o;
  endfunction

  function automatic out_t init_out();
    out_t o;
    o = '0;
    o.rst = 1'b1;
    return o;
  endfunction

  function automatic out_t sample();
    out_t o;
    o = '{pc:PC_IN_MUX_SEL, op1:ALU_OP_1_MUX_SEL, op2:ALU_OP_2_MUX_SEL, alu:ALU_OPCODE,
          we:RF_WR_EN, set:RF_SET, rst:RF_RESET, din:RF_DATA_IN_MUX_SEL,
          dmwe:DATA_MEMORY_WR_EN, size:DATA_MEMORY_SIZE_SEL, sext:DATA_MEMORY_SIGN_EXTEND,
          imm:immediate, s1:RF_SEL_1, s2:RF_SEL_2, rd:RF_SEL_RD};
    return o;
  endfunction

  task automatic add(input logic [31:0] i, input logic [31:0] r1, input logic [31:0] r2,
                     input out_t e, input logic ill, input string nm);
    vec_t v;
    v.instr = i; v.r1 = r1; v.r2 = r2; v.exp = e; v.ill = ill; v.name = nm;
    vecs.push_back(v);
  endtask

  task automatic push(input out_t e, input logic ill, input string nm);
    sb_exp.push_back(e);
    sb_ill.push_back(ill);
    sb_name.push_back(nm);
  endtask

  task automatic check_out();
    out_t  e, a;
    logic  ill;
    string nm;
    checks++;
    if (sb_exp.size() == 0) begin
      errors++;
      $display("FAIL scoreboard_empty: no expected entry for observed output");
      return;
    end
    e = sb_exp.pop_front(); ill = sb_ill.pop_front(); nm = sb_name.pop_front();
    a = sample();
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, a, e);
    end
`ifdef DECODE_ILLEGAL_FLAG_EN
    checks++;
    if (ILLEGAL !== ill) begin
      errors++;
      $display("FAIL %s_illegal: got %b expected %b", nm, ILLEGAL, ill);
    end
`else
    if (ill === 1'bx) $display("note: unknown illegal flag in %s", nm);
`endif
  endtask

  task automatic apply(input vec_t v);
    @(negedge clock);
    instruction = v.instr; REG_1 = v.r1; REG_2 = v.r2;
    push(v.exp, v.ill, v.name);
    #2;
    check_out();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    // ADDI/SUB/ADD/LW/SW/BEQ/JAL/LUI and corner encodings
    add(32'h00500093, 0, 0, mk(0,1,1,3'd0,1,2'd1,0,2'd0,0,32'd5,5'd0,5'd5,5'd1), 0, "addi");
    add(32'h402081B3, 0, 0, mk(0,1,0,3'd1,1,2'd1,0,2'd0,0,32'd0,5'd1,5'd2,5'd3), 0, "sub");
    add(32'h002081B3, 0, 0, mk(0,1,0,3'd0,1,2'd1,0,2'd0,0,32'd0,5'd1,5'd2,5'd3), 0, "add");
    add(32'h00812283, 0, 0, mk(0,1,1,3'd0,1,2'd2,0,2'd2,1,32'd8,5'd2,5'd8,5'd5), 0, "lw");
    add(32'h00512623, 0, 0, mk(0,1,1,3'd0,0,2'd1,1,2'd2,0,32'd12,5'd2,5'd5,5'd12), 0, "sw");
    add(32'h00208463, 7, 7, mk(1,0,1,3'd0,0,2'd1,0,2'd0,0,32'd8,5'd1,5'd2,5'd8), 0, "beq_taken");
    add(32'h00208463, 7, 8, mk(0,0,1,3'd0,0,2'd1,0,2'd0,0,32'd8,5'd1,5'd2,5'd8), 0, "beq_not");
    add(32'h010000EF, 0, 0, mk(1,0,1,3'd0,1,2'd0,0,2'd0,0,32'd16,5'd0,5'd16,5'd1), 0, "jal");
    add(32'h123453B7, 5, 0, mk(0,1,1,3'd0,1,2'd1,0,2'd0,0,32'h12345000,5'd0,5'd3,5'd7), 0, "lui");
    add(32'h00500013, 0, 0, mk(0,1,1,3'd0,0,2'd1,0,2'd0,0,32'd5,5'd0,5'd5,5'd0), 0, "addi_x0");
    add(32'h0020C463, 32'hFFFFFFFF, 1,
        mk(1,0,1,3'd0,0,2'd1,0,2'd0,0,32'd8,5'd1,5'd2,5'd8), 0, "blt_signed");
    add(32'h0020E463, 32'hFFFFFFFF, 1,
        mk(0,0,1,3'd0,0,2'd1,0,2'd0,0,32'd8,5'd1,5'd2,5'd8), 0, "bltu_unsigned");
    add(32'h00502093, 0, 0, mk(0,1,0,3'd0,0,2'd1,0,2'd0,0,32'd0,5'd0,5'd5,5'd1), 1, "slti_nop");
    add(32'h4030D093, 0, 0, mk(0,1,1,3'd7,1,2'd1,0,2'd0,0,32'h403,5'd1,5'd3,5'd1), 0, "srai");
    add(32'h00814283, 0, 0, mk(0,1,1,3'd0,1,2'd2,0,2'd0,0,32'd8,5'd2,5'd8,5'd5), 0, "lbu");
    add(32'hFFF00093, 0, 0,
        mk(0,1,1,3'd0,1,2'd1,0,2'd0,0,32'hFFFFFFFF,5'd0,5'd31,5'd1), 0, "addi_neg");
    add(32'h000100E7, 0, 0, mk(1,1,1,3'd0,1,2'd0,0,2'd0,0,32'd0,5'd2,5'd0,5'd1), 0, "jalr");
    add(32'h00001117, 0, 0, mk(0,0,1,3'd0,1,2'd1,0,2'd0,0,32'h1000,5'd0,5'd0,5'd2), 0, "auipc");

    // Reset state: INIT outputs even with a live instruction on the bus
    reset_n = 1'b0;
    instruction = 32'h00500093;
    @(negedge clock); #2;
    push(init_out(), 1'b0, "reset_init");
    check_out();
    @(negedge clock);
    reset_n = 1'b1;
    #2;
    push(init_out(), 1'b0, "init_before_edge");
    check_out();
    @(posedge clock); #1;
    push(mk(0,1,1,3'd0,1,2'd1,0,2'd0,0,32'd5,5'd0,5'd5,5'd1), 1'b0, "run_after_edge");
    check_out();

    for (int i = 0; i < vecs.size(); i++) apply(vecs[i]);

    // Reset mid-operation returns to INIT asynchronously, then one edge back to RUN
    @(negedge clock);
    instruction = 32'h00512623;
    #1 reset_n = 1'b0;
    #1;
    push(init_out(), 1'b0, "async_reset");
    check_out();
    @(negedge clock);
    reset_n = 1'b1;
    #1;
    push(init_out(), 1'b0, "init_hold");
    check_out();
    @(posedge clock); #1;
    push(mk(0,1,1,3'd0,0,2'd1,1,2'd2,0,32'd12,5'd2,5'd5,5'd12), 1'b0, "sw_after_reset");
    check_out();

    if (sb_exp.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_leftover: %0d entries remain, expected 0", sb_exp.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
